fir_coeff_loader: RTL
=====================

# fir_coeff_loader

Coefficient writer for the FIR filter cores (`fir8_14b_v1_0`, `fir32_14b_v1_0`). It accepts coefficients one word at a time over a valid/ready stream into a shadow bank. On a commit request it transfers the whole bank to the filter's parallel coefficient inputs in one step. The transfer happens only on a sample-strobe (`ce`) cycle, so the filter never runs a sample with a mix of old and new taps.

## Interface

Parameters:
- `N_COEFF`, default 9: number of taps. Use 9 for the 8th-order filter and 33 for the 32nd-order filter.
- `COEFF_W`, default 32: coefficient width in bits, signed.

Ports:
- `clk`, input, 1 bit: system clock (100 MHz).
- `rst`, input, 1 bit: one clock; reset is synchronous and active-high.
- `ce`, input, 1 bit: filter sample strobe. This is the same signal that drives the filter's `ce`.
- `is32_wr_data`, input, `COEFF_W` bits: coefficient word being written.
- `i_wr_valid`, input, 1 bit: write request.
- `o_wr_ready`, output, 1 bit: the loader can accept a word.
- `i_commit`, input, 1 bit: request to transfer the shadow bank to the active bank. Treated as a single-cycle pulse.
- `i_clear`, input, 1 bit: discard the shadow contents and return the write index to 0.
- `o_commit_done`, output, 1 bit: one-cycle pulse when the active bank has been updated.
- `o_commit_err`, output, 1 bit: one-cycle pulse when a commit was rejected.
- `o_pending`, output, 1 bit: a commit is waiting for `ce`.
- `o_wr_index`, output, `$clog2(N_COEFF+1)` bits: number of words in the shadow bank.
- `os_coeff`, output, `N_COEFF*COEFF_W` bits: active bank. Tap k occupies bits `[COEFF_W*k + COEFF_W-1 : COEFF_W*k]` and connects to the filter's `is32_coeff_k`.

## Operation

State machine with three states: LOAD, FULL, PENDING.
- **LOAD**
  - `o_wr_ready`=1.
  - A word is accepted when `i_wr_valid` and `o_wr_ready` are both 1. The word goes to `shadow[o_wr_index]` and the index increments.
  - Accepting word number `N_COEFF-1` moves the state to FULL, with index = `N_COEFF`.
- **FULL**
  - `o_wr_ready`=0. Extra writes are dropped with no side effect.
- **Commit rules**
  - In FULL, `i_commit` moves the state to PENDING.
  - In LOAD, `i_commit` pulses `o_commit_err` for one cycle. The state, index and shadow are unchanged.
  - In PENDING, `i_commit` is ignored with no error.
- **PENDING**
  - `o_wr_ready`=0 and `o_pending`=1.
  - On the first cycle with `ce`=1:
    - `os_coeff` takes the shadow contents (all taps at the same edge);
    - `o_commit_done` pulses;
    - the index goes to 0;
    - the state returns to LOAD.
  - The shadow contents are kept, so an identical bank can be recommitted after reloading.
- **`i_clear`**
  - In LOAD or FULL: index goes to 0 and the state goes to LOAD. The shadow data is don't-care.
  - In PENDING: the pending commit is cancelled, the state goes to LOAD, and `os_coeff` is unchanged.
  - If `i_clear` and `i_commit` arrive in the same cycle, `i_clear` wins and no error pulse is raised.
- **Width rules**
  - Words are stored verbatim; no scaling or saturation.
  - Sign is preserved bit-for-bit, since the filter interprets taps as signed Q1.31.
- **`ce` outside PENDING**: no effect on the loader.

## Timing

- **Reset.** Outputs after the first rising edge with `rst`=1:
  - `os_coeff` = 0 (all taps);
  - state = LOAD, `o_wr_index` = 0, `o_wr_ready` = 1;
  - `o_pending` = 0, `o_commit_done` = 0, `o_commit_err` = 0.
- **Reset during PENDING** cancels the commit; `os_coeff` is 0.
- **Write.** The word is registered at the handshake edge. `o_wr_index` and `o_wr_ready` update at that same edge, so `o_wr_ready` is 0 in the cycle after the N-th accept.
- **Commit latency.**
  - `i_commit` sampled at edge t sets `o_pending`=1 after t.
  - The swap occurs at the first edge t' > t where `ce`=1.
  - `os_coeff` and `o_commit_done` become valid after t'.
  - A `ce` present in the same cycle as `i_commit` does NOT trigger the swap; the next `ce` does.
  - With the 10-cycle `ce` period, worst-case commit latency is 11 cycles.
- **Filter alignment.** The filter samples `os_coeff` on the edge after the swap edge. The first sample using the new taps is the next `ce`. No sample ever sees mixed taps.
- **Error pulse.** `o_commit_err` is registered and asserts in the cycle after the rejected `i_commit`.
- **`o_commit_done`** is high for exactly one cycle per successful commit.
- **Throughput.** One word per cycle while in LOAD; `N_COEFF` cycles to fill the bank.

## Test plan

1. **Full load and commit.**
   - Stimulus: reset; write 9 words of 238609294 back-to-back; pulse `i_commit`; `ce` every 10 cycles.
   - Required: `o_wr_ready` falls after the 9th word; `o_pending` goes high; all 9 taps equal 238609294 one edge after the next `ce`; a single `o_commit_done` pulse.
   - Also instantiate `fir8_14b_v1_0` driven by the loader with `is14_in`=3000 and check that the output settles to the same value as with the hard-wired coefficients.
2. **Short load.**
   - Stimulus: write 5 words, then pulse `i_commit`.
   - Required: `o_commit_err` pulses for one cycle; `os_coeff` stays 0; index stays 5; writing 4 more words and committing then succeeds.
3. **Overflow.**
   - Stimulus: 10 valid writes with the 10th = 0x7FFFFFFF.
   - Required: 10th word not accepted; index = 9; after commit, tap 8 holds the 9th word, not 0x7FFFFFFF.
4. **Commit coincident with `ce`.**
   - Stimulus: `i_commit` and `ce` high in the same cycle.
   - Required: no swap at that edge; swap exactly at the next `ce` (10 cycles later).
5. **Cancellation and reset.**
   - Stimulus: in PENDING, assert `i_clear` (run A) or `rst` (run B) before `ce`.
   - Required: no `o_commit_done`; run A keeps the previous active bank; run B shows all taps 0; both return to LOAD with index 0.
6. **Wide configuration.**
   - Stimulus: `N_COEFF`=33; load 33 words of 65619885 with alternating negative values (-65619885); commit.
   - Required: taps match sign-exactly at bit offsets 32k; `o_commit_done` pulses once.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: streams FIR coefficients into a shadow bank. On a commit
// request, the whole bank is copied to the active taps on the next sample
// strobe, so the filter never sees a mix of old and new taps.
module fir_coeff_loader #(
  parameter int N_COEFF = 9,
  parameter int COEFF_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ce,
  input  logic [COEFF_W-1:0]                  is32_wr_data,
  input  logic                                i_wr_valid,
  output logic                                o_wr_ready,
  input  logic                                i_commit,
  input  logic                                i_clear,
  output logic                                o_commit_done,
  output logic                                o_commit_err,
  output logic                                o_pending,
  output logic [$clog2(N_COEFF+1)-1:0]        o_wr_index,
  output logic [N_COEFF*COEFF_W-1:0]          os_coeff
);

  localparam int IDX_W = $clog2(N_COEFF + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    FULL    = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               done_reg;
  logic               err_reg;
  logic [COEFF_W-1:0] shadow_reg [N_COEFF];
  logic [COEFF_W-1:0] active_reg [N_COEFF];

  // Loader FSM: accepts words, arbitrates commit/clear, and swaps the active
  // bank on the first sample strobe seen while a commit is pending. Clear takes
  // priority over everything except reset; the shadow data is never cleared,
  // so a bank can be recommitted after a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      for (int k = 0; k < N_COEFF; k++) begin
        active_reg[k] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (i_clear) begin
        state_reg <= LOAD;
        idx_reg   <= '0;
      end else begin
        case (state_reg)
          LOAD: begin
            if (i_wr_valid) begin
              shadow_reg[idx_reg] <= is32_wr_data;
              idx_reg             <= idx_reg + 1'b1;
              if (idx_reg == LAST_IDX) begin
                state_reg <= FULL;
              end
            end
            // A commit before the bank is complete is rejected.
            if (i_commit) begin
              err_reg <= 1'b1;
            end
          end
          FULL: begin
            if (i_commit) begin
              state_reg <= PENDING;
            end
          end
          PENDING: begin
            if (ce) begin
              for (int k = 0; k < N_COEFF; k++) begin
                active_reg[k] <= shadow_reg[k];
              end
              done_reg  <= 1'b1;
              idx_reg   <= '0;
              state_reg <= LOAD;
            end
          end
          default: begin
            state_reg <= LOAD;
            idx_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign o_wr_ready    = (state_reg == LOAD);
  assign o_pending     = (state_reg == PENDING);
  assign o_commit_done = done_reg;
  assign o_commit_err  = err_reg;
  assign o_wr_index    = idx_reg;

  // Tap k sits at bit offset COEFF_W*k of the flattened coefficient bus.
  generate
    for (genvar gi = 0; gi < N_COEFF; gi++) begin : g_tap
      assign os_coeff[gi*COEFF_W +: COEFF_W] = active_reg[gi];
    end
  endgenerate

endmodule
